mips_fetch_queue: RTL and testbench

MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

---
 rtl/mips_fetch_queue.sv | 81 ++++++++
 tb/tb_mips_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction fetch FSM feeding an IF/ID queue, flushed by taken-branch redirects
module mips_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [9:0]               imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [9:0]               redirect_pc,
  input  logic                     halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_npc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state;
  logic [9:0] fpc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] q_ir [DEPTH];
  logic [31:0] q_npc [DEPTH];
  logic push, pop, go;
  logic [AW:0] count_next;
  logic [9:0] next_addr;
  logic [31:0] npc;
  assign push = state == WAIT && imem_ack && !redirect;
  assign pop = out_valid && out_ready && !redirect;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign go = !halt && count_next < FULL;
  assign next_addr = imem_addr + 10'd1;
  assign npc = {22'd0, imem_addr} + 32'd1;
  assign imem_req = state != IDLE;
  assign out_valid = count != '0;
  assign out_ir = q_ir[rd_ptr];
  assign out_npc = q_npc[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fpc <= RESET_PC;
      imem_addr <= RESET_PC;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_ir[i] <= '0;
        q_npc[i] <= '0;
      end
    end else begin
      count <= redirect ? '0 : count_next;
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
      if (push) begin
        q_ir[wr_ptr] <= imem_rdata;
        q_npc[wr_ptr] <= npc;
      end
      if (redirect) fpc <= redirect_pc;
      else if (push) fpc <= next_addr;
      case (state)
        IDLE: if (!redirect && go) begin
          state <= WAIT;
          imem_addr <= fpc;
        end
        // a redirect with the ack in hand can drop the data now; otherwise the live request must drain
        WAIT: if (redirect) state <= imem_ack ? IDLE : DRAIN;
          else if (imem_ack) begin
            if (go) imem_addr <= next_addr;
            else state <= IDLE;
          end
        DRAIN: if (imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb_mips_fetch_queue: table-driven and scoreboard checks of the fetch queue
module tb_mips_fetch_queue;
  logic clk = 0, rst = 1, imem_req, imem_ack, redirect = 0, halt = 0, out_valid, out_ready = 0;
  logic [9:0] imem_addr, redirect_pc = '0;
  logic [31:0] imem_rdata, out_ir, out_npc;
  logic [2:0] count;
  logic auto_ack = 1, man_ack = 0;
  int n_cmp = 0, n_err = 0;
  logic [63:0] sb [$];
  typedef struct packed {logic rdy; logic req; logic [2:0] cnt; logic [9:0] addr;} vec_t;
  vec_t bp [9];
  assign imem_ack = auto_ack ? imem_req : man_ack;
  assign imem_rdata = 32'h100 + {22'd0, imem_addr};
  always #5 clk = ~clk;
  mips_fetch_queue dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_npc(out_npc), .count(count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic exp_push(input logic [31:0] ir, input logic [31:0] npc);
    sb.push_back({ir, npc});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; redirect = 0; halt = 0; out_ready = 0; auto_ack = 1; man_ack = 0; redirect_pc = '0;
    #2;
    sb.delete();
    @(posedge clk);
    #1 rst = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_unexpected: got ir=%h npc=%h expected no output", out_ir, out_npc);
      end else begin : pop_blk
        logic [63:0] e;
        e = sb.pop_front();
        chk("pop_ir", out_ir, e[63:32]);
        chk("pop_npc", out_npc, e[31:0]);
      end
    end
  end
  initial begin
    bp[0] = '{1'b0, 1'b1, 3'd0, 10'd0};
    bp[1] = '{1'b0, 1'b1, 3'd1, 10'd1};
    bp[2] = '{1'b0, 1'b1, 3'd2, 10'd2};
    bp[3] = '{1'b0, 1'b1, 3'd3, 10'd3};
    bp[4] = '{1'b0, 1'b0, 3'd4, 10'd3};
    bp[5] = '{1'b0, 1'b0, 3'd4, 10'd3};
    bp[6] = '{1'b1, 1'b1, 3'd3, 10'd4};
    bp[7] = '{1'b1, 1'b1, 3'd3, 10'd5};
    bp[8] = '{1'b1, 1'b1, 3'd3, 10'd6};
    step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_ir", out_ir, 0);
    chk("rst_npc", out_npc, 0);
    // streaming with a zero-wait memory
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) exp_push(32'h100 + 32'(i), 32'(i + 1));
    step();
    chk("str_req", 32'(imem_req), 1);
    chk("str_addr0", 32'(imem_addr), 0);
    chk("str_valid0", 32'(out_valid), 0);
    step();
    chk("str_valid1", 32'(out_valid), 1);
    chk("str_ir1", out_ir, 32'h100);
    repeat (8) step();
    chk("str_count", 32'(count), 1);
    chk("str_addr9", 32'(imem_addr), 9);
    chk("str_left", 32'(sb.size()), 2);
    // backpressure table
    do_reset();
    for (int i = 0; i < 7; i++) exp_push(32'h100 + 32'(i), 32'(i + 1));
    for (int k = 0; k < 9; k++) begin
      out_ready = bp[k].rdy;
      step();
      chk("bp_req", 32'(imem_req), 32'(bp[k].req));
      chk("bp_count", 32'(count), 32'(bp[k].cnt));
      chk("bp_addr", 32'(imem_addr), 32'(bp[k].addr));
    end
    chk("bp_head", out_ir, 32'h103);
    // push and pop together at count 2
    do_reset();
    for (int i = 0; i < 4; i++) exp_push(32'h100 + 32'(i), 32'(i + 1));
    repeat (3) step();
    chk("sim_count0", 32'(count), 2);
    chk("sim_head0", out_ir, 32'h100);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("sim_count1", 32'(count), 2);
    chk("sim_head1", out_ir, 32'h101);
    // redirect while a slow request is live
    do_reset();
    auto_ack = 0;
    out_ready = 1;
    step();
    chk("rd_req0", 32'(imem_req), 1);
    step();
    redirect = 1; redirect_pc = 10'h200;
    step();
    redirect = 0;
    chk("rd_drain_req", 32'(imem_req), 1);
    chk("rd_count0", 32'(count), 0);
    step();
    man_ack = 1;
    step();
    man_ack = 0;
    chk("rd_idle_req", 32'(imem_req), 0);
    chk("rd_valid0", 32'(out_valid), 0);
    step();
    chk("rd_addr", 32'(imem_addr), 32'h200);
    chk("rd_req1", 32'(imem_req), 1);
    exp_push(32'h300, 32'h201);
    man_ack = 1;
    step();
    man_ack = 0;
    chk("rd_valid1", 32'(out_valid), 1);
    chk("rd_ir", out_ir, 32'h300);
    step();
    chk("rd_left", 32'(sb.size()), 0);
    // halt mid-request, then redirect to the top of memory and wrap
    do_reset();
    exp_push(32'h100, 1); exp_push(32'h4ff, 1024); exp_push(32'h100, 1); exp_push(32'h101, 2);
    step();
    halt = 1;
    step();
    chk("hw_req0", 32'(imem_req), 0);
    chk("hw_count1", 32'(count), 1);
    step(); step();
    chk("hw_req_halt", 32'(imem_req), 0);
    out_ready = 1;
    step();
    chk("hw_count0", 32'(count), 0);
    halt = 0; redirect = 1; redirect_pc = 10'd1023;
    step();
    redirect = 0;
    chk("hw_req_rd", 32'(imem_req), 0);
    step();
    chk("hw_addr1023", 32'(imem_addr), 1023);
    step();
    chk("hw_addr0", 32'(imem_addr), 0);
    chk("hw_npc1024", out_npc, 1024);
    repeat (3) step();
    chk("hw_left", 32'(sb.size()), 0);
    // asynchronous reset mid-request with three entries queued
    do_reset();
    repeat (4) step();
    chk("ar_count3", 32'(count), 3);
    chk("ar_req1", 32'(imem_req), 1);
    #2 rst = 1;
    #1;
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_ir", out_ir, 0);
    halt = 1; auto_ack = 0; man_ack = 1;
    @(posedge clk);
    #1 rst = 0;
    step(); step();
    chk("ar_stale_count", 32'(count), 0);
    chk("ar_stale_req", 32'(imem_req), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
